// File: rtl/param_stack.sv
// param_stack: LIFO stack with registered overflow/underflow flags.
// Define PARAM_STACK_STICKY_ERR_EN to make the error flags hold until reset.
module param_stack #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_en,
    input  logic             io_push,
    input  logic             io_pop,
    input  logic [WIDTH-1:0] io_dataIn,
    output logic [WIDTH-1:0] io_dataOut,
    output logic [CW-1:0]    io_count,
    output logic             io_empty,
    output logic             io_full,
    output logic             io_overflow,
    output logic             io_underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    sp_q, sp_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             push_only, pop_only, both, empty, full, we;
    logic [AW-1:0]    top_idx, waddr;

    always_comb begin
        empty     = sp_q == '0;
        full      = sp_q == DEPTH_C;
        push_only = io_en && io_push && !io_pop;
        pop_only  = io_en && io_pop && !io_push;
        both      = io_en && io_push && io_pop;
        top_idx   = AW'(sp_q - 1'b1);
        we        = (push_only && !full) || both;
        // push+pop on a non-empty stack overwrites the top in place
        waddr     = (both && !empty) ? top_idx : AW'(sp_q);
        sp_d      = ((push_only && !full) || (both && empty)) ? sp_q + 1'b1 :
                    (pop_only && !empty) ? sp_q - 1'b1 : sp_q;
`ifdef PARAM_STACK_STICKY_ERR_EN
        ovf_d     = ovf_q || (push_only && full);
        unf_d     = unf_q || (pop_only && empty);
`else
        ovf_d     = push_only && full;
        unf_d     = pop_only && empty;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    always_ff @(posedge clock) begin
        if (we && !reset) mem_q[waddr] <= io_dataIn;
    end

    assign io_dataOut   = empty ? '0 : mem_q[top_idx];
    assign io_count     = sp_q;
    assign io_empty     = empty;
    assign io_full      = full;
    assign io_overflow  = ovf_q;
    assign io_underflow = unf_q;
endmodule

// File: doc/param_stack.md
PARAM_STACK -- requirements
Module: param_stack

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits (1..64).
REQ-002 Parameter DEPTH, default 16, number of entries (power of two, 2..1024).
REQ-003 Parameter CW, default $clog2(DEPTH+1), width of io_count (derived; not overridden).
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 io_en  input  1  operation enable; when 0 the push and pop inputs are ignored.
REQ-007 io_push  input  1  push request.
REQ-008 io_pop  input  1  pop request.
REQ-009 io_dataIn  input  WIDTH  data to push.
REQ-010 io_dataOut  output  WIDTH  current top-of-stack value; 0 when empty.
REQ-011 io_count  output  CW  number of valid entries (0..DEPTH).
REQ-012 io_empty  output  1  high when io_count==0.
REQ-013 io_full  output  1  high when io_count==DEPTH.
REQ-014 io_overflow  output  1  push-rejected error flag (registered).
REQ-015 io_underflow  output  1  pop-rejected error flag (registered).

Function
REQ-016 Storage shall be DEPTH x WIDTH entries, with a stack pointer sp equal to io_count; entry sp-1 is the top.
REQ-017 Operations shall be evaluated only when io_en=1; with io_en=0 the storage, sp and top shall be unchanged.
REQ-018 Push only, not full: write io_dataIn to mem[sp] and set sp:=sp+1 at the edge.
REQ-019 Push only, full: drop the data, leave sp and storage unchanged, and assert io_overflow in the following cycle.
REQ-020 Pop only, not empty: set sp:=sp-1 at the edge; discarded data need not be cleared.
REQ-021 Pop only, empty: leave sp unchanged and assert io_underflow in the following cycle.
REQ-022 Push and pop together, not empty (including full): replace the top, i.e. mem[sp-1]:=io_dataIn, with sp unchanged and no error flag.
REQ-023 Push and pop together, empty: behave as a push (sp:=1, mem[0]:=io_dataIn), with no underflow.
REQ-024 io_dataOut shall equal mem[sp-1] combinationally from registered state; the value pushed at edge N is visible in the cycle after edge N (zero added latency).
REQ-025 io_dataOut shall be 0 whenever sp==0.
REQ-026 io_count, io_empty and io_full shall be driven directly from registered sp, with no combinational path from the inputs.
REQ-027 sp arithmetic shall be CW bits wide and shall never wrap: sp stays within 0..DEPTH under all input combinations.
REQ-028 Error flags shall be registered and shall never depend combinationally on the inputs.

Reset
REQ-029 At a rising edge with reset=1: sp:=0, io_overflow:=0 and io_underflow:=0; any concurrent push or pop is ignored.
REQ-030 After reset: io_dataOut=0, io_count=0, io_empty=1, io_full=0; the storage contents are not reset.
REQ-031 Reset asserted mid-sequence shall discard all entries at that edge, and an erroring request in the same cycle shall set no flag.

Configuration
REQ-032 Macro PARAM_STACK_STICKY_ERR_EN selects the error-flag behaviour.
REQ-033 With PARAM_STACK_STICKY_ERR_EN defined: io_overflow and io_underflow, once set, stay high until reset.
REQ-034 With PARAM_STACK_STICKY_ERR_EN undefined: each flag is a one-cycle pulse per offending request (high for N consecutive cycles after N consecutive offending requests).

Verification
REQ-035 Reset, then push 0x11, 0x22, 0x33 (io_en=1) -> io_count=3, io_dataOut=0x33; three pops -> io_dataOut 0x22, 0x11, 0, io_empty=1.
REQ-036 DEPTH=4: push 1..4 -> io_full=1; push 5 -> io_overflow high the next cycle, io_count=4, io_dataOut=4; pop -> io_dataOut=3.
REQ-037 Empty stack, pop -> io_underflow=1 the next cycle, io_count=0; the flag is high one cycle (macro off) or stays high until reset (macro on).
REQ-038 Stack holding 0xA, 0xB, push+pop of 0xC -> io_count=2, io_dataOut=0xC; empty stack, push+pop of 0xD -> io_count=1, io_dataOut=0xD, no error flag.
REQ-039 io_en=0 with push=1 and pop=1 for 5 cycles -> all outputs unchanged; then reset=1 alongside push 0x55 -> io_count=0 and io_dataOut=0 after the edge.
